// File: rtl/downstream_accum_ctrl_pkg.sv
// Shared types and default constants for the downstream accumulation sequencer.
package downstream_accum_ctrl_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int IDX_W_DEF   = 10;
  localparam int DATA_W_DEF  = 32;
  localparam int CNT_W_DEF   = 16;

  // Stored totals must stay strictly below this value; mirrors the RAM's own drop rule.
  localparam logic [31:0] ACC_LIMIT_DEF = 32'h0000_FFAA;

  typedef struct packed {
    logic [IDX_W_DEF-1:0]  idx;
    logic [DATA_W_DEF-1:0] amount;
  } accum_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2
  } accum_state_t;

endpackage

// File: rtl/downstream_accum_ctrl_if.sv
// Request, response, RAM and statistics signals of the downstream accumulation sequencer.
interface downstream_accum_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 10,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
);
  localparam int SRC_W = $clog2(NUM_REQ);

  // Request i transfers on req_valid[i] & req_ready[i]. req_ready is one-hot and only
  // asserted in IDLE; a requester holds valid/idx/amount stable until granted and may drop
  // valid before a grant. rsp_valid is a one-cycle pulse with no backpressure.
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*IDX_W-1:0]  req_idx;
  logic [NUM_REQ*DATA_W-1:0] req_amount;

  logic                      rsp_valid;
  logic [SRC_W-1:0]          rsp_src;
  logic                      rsp_ok;
  logic [DATA_W-1:0]         rsp_total;

  logic [IDX_W-1:0]          ram_rdindex;
  logic [IDX_W-1:0]          ram_wrindex;
  logic                      ram_we;
  logic [DATA_W-1:0]         ram_wdata;
  logic [DATA_W-1:0]         ram_rdata;

  logic [CNT_W-1:0]          acc_count;
  logic [CNT_W-1:0]          rej_count;

  modport master (
    output req_valid, req_idx, req_amount, ram_rdata,
    input  req_ready, rsp_valid, rsp_src, rsp_ok, rsp_total,
    input  ram_rdindex, ram_wrindex, ram_we, ram_wdata, acc_count, rej_count
  );

  modport slave (
    input  req_valid, req_idx, req_amount, ram_rdata,
    output req_ready, rsp_valid, rsp_src, rsp_ok, rsp_total,
    output ram_rdindex, ram_wrindex, ram_we, ram_wdata, acc_count, rej_count
  );
endinterface

// File: rtl/downstream_accum_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, cyclically.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  always_comb begin
    logic found;
    int   pos;
    grant = '0;
    found = 1'b0;
    pos   = 0;
    for (int off = 0; off < N; off++) begin
      pos = (int'(ptr) + off) % N;
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/downstream_accum_ctrl.sv
// Round-robin read-check-write sequencer in front of the downstream accumulation RAM.
module downstream_accum_ctrl
  import downstream_accum_ctrl_pkg::*;
#(
  parameter int              NUM_REQ   = NUM_REQ_DEF,
  parameter int              IDX_W     = IDX_W_DEF,
  parameter int              DATA_W    = DATA_W_DEF,
  parameter int              CNT_W     = CNT_W_DEF,
  parameter logic [DATA_W-1:0] ACC_LIMIT = DATA_W'(ACC_LIMIT_DEF)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  downstream_accum_ctrl_if.slave  bus,
  output accum_state_t            state_dbg
);

  localparam int SRC_W = $clog2(NUM_REQ);

  accum_state_t        state;
  logic [SRC_W-1:0]    rr_ptr;
  logic [SRC_W-1:0]    cur_src;
  logic [IDX_W-1:0]    cur_idx;
  logic [DATA_W-1:0]   cur_amount;

  logic [NUM_REQ-1:0]  grant;
  logic [SRC_W-1:0]    gnt_src;
  logic [IDX_W-1:0]    cand_idx;
  logic [DATA_W-1:0]   cand_amount;
  logic [DATA_W:0]     sum;
  logic                ok;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    gnt_src = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_src = SRC_W'(i);
    end
  end

  assign cand_idx    = bus.req_idx[gnt_src*IDX_W +: IDX_W];
  assign cand_amount = bus.req_amount[gnt_src*DATA_W +: DATA_W];

  // Gating with rst_n keeps the grant low while reset is held, even with valids present.
  assign bus.req_ready   = (state == IDLE && rst_n) ? grant : '0;
  assign bus.ram_rdindex = (state == IDLE) ? cand_idx : cur_idx;

  // One extra bit so a carry out of DATA_W lands above the limit and is rejected.
  assign sum = {1'b0, bus.ram_rdata} + {1'b0, cur_amount};
  assign ok  = (sum < {1'b0, ACC_LIMIT});

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      cur_src         <= '0;
      cur_idx         <= '0;
      cur_amount      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_src     <= '0;
      bus.rsp_ok      <= 1'b0;
      bus.rsp_total   <= '0;
      bus.ram_we      <= 1'b0;
      bus.ram_wrindex <= '0;
      bus.ram_wdata   <= '0;
      bus.acc_count   <= '0;
      bus.rej_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            cur_src    <= gnt_src;
            cur_idx    <= cand_idx;
            cur_amount <= cand_amount;
            state      <= CHECK;
          end
        end
        CHECK: begin
          bus.ram_we      <= ok;
          bus.ram_wrindex <= cur_idx;
          bus.ram_wdata   <= cur_amount;
          bus.rsp_valid   <= 1'b1;
          bus.rsp_src     <= cur_src;
          bus.rsp_ok      <= ok;
          bus.rsp_total   <= ok ? sum[DATA_W-1:0] : bus.ram_rdata;
          if (ok) begin
            if (!(&bus.acc_count)) bus.acc_count <= bus.acc_count + 1'b1;
          end else begin
            if (!(&bus.rej_count)) bus.rej_count <= bus.rej_count + 1'b1;
          end
          state <= WRITE;
        end
        WRITE: begin
          bus.ram_we    <= 1'b0;
          bus.rsp_valid <= 1'b0;
          rr_ptr        <= (cur_src == SRC_W'(NUM_REQ - 1)) ? '0 : cur_src + 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/downstream_accum_ctrl.md
# downstream_accum_ctrl

Sequencer and arbiter in front of the downstream accumulation RAM (`dm_data_downstream`), which stores one accumulated cancelled-order total per client ID. Accepts accumulate requests from `NUM_REQ` upstream sources and grants them round-robin. For each granted request it performs a read-check-write sequence against the RAM, so the requester learns whether its amount was applied or rejected for exceeding the accumulation limit. It also keeps running accepted and rejected counters for the host.

## Interface
- `NUM_REQ`, 4 — number of requesters (2..8).
- `IDX_W`, 10 — client-ID width; RAM depth 2^IDX_W = 1024.
- `DATA_W`, 32 — amount / accumulated value width.
- `ACC_LIMIT`, 32'h0000_FFAA — totals must stay strictly below this.
- `CNT_W`, 16 — width of the statistics counters.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ  per-source request valid.
- `req_ready`  out  NUM_REQ  one-hot grant; handshake completes when valid & ready.
- `req_idx`  in  NUM_REQ*IDX_W  packed client IDs; source i at [i*IDX_W +: IDX_W].
- `req_amount`  in  NUM_REQ*DATA_W  packed amounts.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_src`  out  $clog2(NUM_REQ)  source number being answered.
- `rsp_ok`  out  1  1 = amount applied; 0 = rejected by limit.
- `rsp_total`  out  DATA_W  new total if ok, else the unchanged stored total.
- `ram_rdindex`, `ram_wrindex`  out  IDX_W  RAM read and write indices.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  DATA_W  increment; the RAM adds it to the stored value.
- `ram_rdata`  in  DATA_W  RAM combinational read data at `ram_rdindex`.
- `acc_count`, `rej_count`  out  CNT_W  accepted / rejected request counts; saturate at all-ones.

## Operation
- FSM states: IDLE, CHECK, WRITE. One request is in flight at a time.
- IDLE:
  - If any `req_valid` is set, the arbiter picks the first valid source at or after `rr_ptr`, cyclically.
  - Assert `req_ready[g]` combinationally for that source only.
  - Latch source, idx and amount; drive `ram_rdindex` = idx; go to CHECK.
- CHECK:
  - Compute `sum` = `ram_rdata` + amount in DATA_W+1 bits; `ok` = (`sum` < `ACC_LIMIT`).
  - Register `ok`, the sum, and the stored value; go to WRITE.
- WRITE:
  - `ram_we` = `ok`, `ram_wrindex` = latched idx, `ram_wdata` = amount.
  - Pulse `rsp_valid` with `rsp_src`, `rsp_ok`, `rsp_total`.
  - Increment `acc_count` or `rej_count`.
  - Set `rr_ptr` = granted source + 1, mod NUM_REQ; return to IDLE.
- The controller's limit check mirrors the RAM's own drop rule. A write with `ok` = 0 is never issued.
- An amount of 0 is a valid request and is accepted whenever the stored total is below `ACC_LIMIT`.
- A carry out of DATA_W is treated as a rejection.
- `ram_rdindex` holds the latched idx during CHECK and WRITE. In IDLE it shows the candidate idx.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_ok` = 0, `rsp_total` = 0, `rsp_src` = 0.
  - `ram_we` = 0, `ram_wrindex` = 0, `ram_wdata` = 0.
  - Counters = 0, `rr_ptr` = 0, state = IDLE.
- Reset mid-sequence aborts the request; no `ram_we` is issued and no response is sent.
- Latency: grant in cycle 0, RAM write and `rsp_valid` in cycle 2. Throughput is one request per 3 cycles.
- `req_ready` is asserted only in IDLE. Requesters hold valid, idx and amount stable until granted. Dropping valid before grant is allowed.
- Back-to-back requests to the same idx are hazard-free: the next read starts the cycle after WRITE, and the RAM updates on that edge.
- No backpressure on the response path. The consumer must accept `rsp_valid` every time it pulses.

## Structure
- Add to `cache_def`:
  - the `ACC_LIMIT` default constant;
  - typedef `accum_req_t` {idx, amount};
  - enum `accum_state_t` {IDLE, CHECK, WRITE}.
- Sub-module `rr_arbiter`, parameterised by N, with inputs req, ptr and output one-hot grant. It is reused by future downstream sequencers.
- The RAM is instantiated outside this block. The controller drives the RAM's `cache_req_type` fields through a wrapper at the top level.

## Test plan
- Single request, src 0, idx 5, amount 0x10, RAM[5] = 0 → at cycle 2 `ram_we` = 1, `ram_wdata` = 0x10; `rsp_ok` = 1, `rsp_total` = 0x10; `acc_count` = 1.
- RAM[7] = 0xFF00, amount 0xAA → `sum` = 0xFFAA is not below the limit, so `rsp_ok` = 0, `rsp_total` = 0xFF00, no `ram_we`, `rej_count` = 1.
- All 4 sources valid continuously → grants are 0, 1, 2, 3, 0 in order, spaced 3 cycles apart.
- Sources 1 and 2 both hit idx 9 with amount 1, RAM[9] = 0 → responses give totals 1 then 2; RAM[9] ends at 2.
- `rst_n` pulled low during CHECK → no write, no response; all outputs return to reset values; the next request after reset is served by source 0.
- 0xFFFF accepted requests with `CNT_W` = 16 → `acc_count` saturates at 0xFFFF and does not wrap.
